// File: rtl/sha256_block_feeder.sv
// -----------------------------------------------------------------------------
// sha256_block_feeder
//
// Upstream driver for a SHA-256 compression round engine. It takes a message
// as a byte stream, applies SHA-256 padding (0x80, zero fill, 64-bit
// big-endian bit length) and presents each 512-bit block with the current
// chaining value to the engine. Then it waits for the engine's result and
// chains it into the next block. When the last block is done it emits the
// digest with a one-cycle valid pulse.
//
// Ports:
//   clk         in   system clock, rising edge
//   rst_n       in   asynchronous active-low reset
//   data_in     in   [7:0] message byte
//   data_v      in   data_in valid (taken when data_ready)
//   msg_end     in   end-of-message pulse (taken when data_ready)
//   data_ready  out  feeder accepts a byte / msg_end this cycle
//   core_H_in   out  [255:0] chaining value to the engine
//   core_M      out  [511:0] message block to the engine
//   core_in_v   out  one-cycle engine load strobe
//   core_H_out  in   [255:0] engine result
//   core_out_v  in   engine done strobe
//   digest      out  [255:0] final hash, held until the next one completes
//   digest_v    out  one-cycle digest valid pulse
// -----------------------------------------------------------------------------
module sha256_block_feeder #(
  parameter int CNT_W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [7:0]   data_in,
  input  logic         data_v,
  input  logic         msg_end,
  output logic         data_ready,
  output logic [255:0] core_H_in,
  output logic [511:0] core_M,
  output logic         core_in_v,
  input  logic [255:0] core_H_out,
  input  logic         core_out_v,
  output logic [255:0] digest,
  output logic         digest_v
);

  typedef enum logic [2:0] {
    S_FILL = 3'd0,
    S_PAD  = 3'd1,
    S_LEN  = 3'd2,
    S_HASH = 3'd3,
    S_DONE = 3'd4
  } state_t;

  localparam logic [255:0] IV = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;

  state_t             r_state;
  state_t             w_state_next;
  state_t             r_ret;        // state to resume after the current hash
  state_t             w_ret_next;
  logic               r_run;        // holds data_ready low until the first clock after reset
  logic [CNT_W-1:0]   r_byte_cnt;
  logic [5:0]         r_blk_pos;
  logic [511:0]       r_blk;
  logic [255:0]       r_h;
  logic [255:0]       r_digest;
  logic               r_digest_v;
  logic               r_core_in_v;
  logic               r_pad_done;   // 0x80 terminator already placed
  logic               w_byte_acc;
  logic               w_end_acc;
  logic [63:0]        w_len;

  assign data_ready = r_run && (r_state == S_FILL);
  assign w_byte_acc = data_ready && data_v;
  assign w_end_acc  = data_ready && msg_end;
  assign w_len      = 64'(r_byte_cnt) << 3;

  assign core_M     = r_blk;
  assign core_H_in  = r_h;
  assign core_in_v  = r_core_in_v;
  assign digest     = r_digest;
  assign digest_v   = r_digest_v;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_FILL;
      r_ret   <= S_FILL;
    end else begin
      r_state <= w_state_next;
      r_ret   <= w_ret_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    w_ret_next   = r_ret;
    case (r_state)
      S_FILL: begin
        if (w_byte_acc && (r_blk_pos == 6'd63)) begin
          // Block full; an end arriving with the last byte is remembered
          // by resuming in PAD instead of FILL.
          w_state_next = S_HASH;
          w_ret_next   = w_end_acc ? S_PAD : S_FILL;
        end else if (w_end_acc) begin
          w_state_next = S_PAD;
        end
      end
      S_PAD: begin
        // Position 63 always closes the block; position 55 is the last byte
        // before the length field and can only be reached once 0x80 is in.
        if (r_blk_pos == 6'd63) begin
          w_state_next = S_HASH;
          w_ret_next   = S_PAD;
        end else if (r_blk_pos == 6'd55) begin
          w_state_next = S_LEN;
        end
      end
      S_LEN: begin
        w_state_next = S_HASH;
        w_ret_next   = S_DONE;
      end
      S_HASH: begin
        if (core_out_v) begin
          w_state_next = r_ret;
        end
      end
      S_DONE: begin
        w_state_next = S_FILL;
      end
      default: begin
        w_state_next = S_FILL;
      end
    endcase
  end

  // Datapath: block buffer, counters, chaining value and strobes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_run       <= 1'b0;
      r_byte_cnt  <= '0;
      r_blk_pos   <= '0;
      r_blk       <= '0;
      r_h         <= IV;
      r_digest    <= '0;
      r_digest_v  <= 1'b0;
      r_core_in_v <= 1'b0;
      r_pad_done  <= 1'b0;
    end else begin
      r_run       <= 1'b1;
      // Load strobe only on entry into HASH, so it lasts exactly one cycle
      r_core_in_v <= (w_state_next == S_HASH) && (r_state != S_HASH);
      // Digest is captured directly from the engine so it is valid in the
      // same cycle as the pulse.
      r_digest_v  <= (r_state == S_HASH) && core_out_v && (r_ret == S_DONE);

      case (r_state)
        S_FILL: begin
          if (w_byte_acc) begin
            // byte k sits at bits 511-8k, i.e. {~k, 3'b111}
            r_blk[{~r_blk_pos, 3'b111} -: 8] <= data_in;
            r_blk_pos  <= r_blk_pos + 6'd1;
            r_byte_cnt <= r_byte_cnt + CNT_W'(1);
          end
          if (w_end_acc) begin
            r_pad_done <= 1'b0;
          end
        end
        S_PAD: begin
          r_blk[{~r_blk_pos, 3'b111} -: 8] <= r_pad_done ? 8'h00 : 8'h80;
          r_pad_done <= 1'b1;
          r_blk_pos  <= r_blk_pos + 6'd1;
        end
        S_LEN: begin
          r_blk[63:0] <= w_len;
        end
        S_HASH: begin
          // Buffer and H stay untouched until the result arrives; the engine
          // reads them right up to its done strobe.
          if (core_out_v) begin
            r_h       <= core_H_out;
            r_blk     <= '0;
            r_blk_pos <= '0;
            if (r_ret == S_DONE) begin
              r_digest <= core_H_out;
            end
          end
        end
        S_DONE: begin
          r_h        <= IV;
          r_byte_cnt <= '0;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sha256_block_feeder.sv
// -----------------------------------------------------------------------------
// tb_sha256_block_feeder
//
// Drives directed messages into sha256_block_feeder. It also models the
// compression engine, which responds 64 cycles after each load using the
// feeder's live core_H_in/core_M. Results are checked against known SHA-256
// digests and hand-built padded blocks.
// -----------------------------------------------------------------------------
module tb_sha256_block_feeder;

  localparam logic [255:0] IV        = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
  localparam logic [255:0] DIG_EMPTY = 256'he3b0c442_98fc1c14_9afbf4c8_996fb924_27ae41e4_649b934c_a495991b_7852b855;
  localparam logic [255:0] DIG_ABC   = 256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
  localparam logic [255:0] DIG_56    = 256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;

  localparam logic [31:0] K_TAB [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic [7:0]   data_in = 8'h00;
  logic         data_v = 1'b0;
  logic         msg_end = 1'b0;
  logic         data_ready;
  logic [255:0] core_H_in;
  logic [511:0] core_M;
  logic         core_in_v;
  logic [255:0] core_H_out = '0;
  logic         core_out_v = 1'b0;
  logic [255:0] digest;
  logic         digest_v;

  sha256_block_feeder #(.CNT_W(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .data_in    (data_in),
    .data_v     (data_v),
    .msg_end    (msg_end),
    .data_ready (data_ready),
    .core_H_in  (core_H_in),
    .core_M     (core_M),
    .core_in_v  (core_in_v),
    .core_H_out (core_H_out),
    .core_out_v (core_out_v),
    .digest     (digest),
    .digest_v   (digest_v)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- reference SHA-256 compression ----------------
  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [255:0] sha_compress(input logic [255:0] h, input logic [511:0] m);
    logic [31:0] w [0:63];
    logic [31:0] a, b, c, d, e, f, g, hh, t1, t2, s0, s1;
    for (int i = 0; i < 16; i++) w[i] = m[511 - 32*i -: 32];
    for (int i = 16; i < 64; i++) begin
      s0 = ror(w[i-15], 7) ^ ror(w[i-15], 18) ^ (w[i-15] >> 3);
      s1 = ror(w[i-2], 17) ^ ror(w[i-2], 19) ^ (w[i-2] >> 10);
      w[i] = w[i-16] + s0 + w[i-7] + s1;
    end
    {a, b, c, d, e, f, g, hh} = h;
    for (int i = 0; i < 64; i++) begin
      s1 = ror(e, 6) ^ ror(e, 11) ^ ror(e, 25);
      t1 = hh + s1 + ((e & f) ^ (~e & g)) + K_TAB[i] + w[i];
      s0 = ror(a, 2) ^ ror(a, 13) ^ ror(a, 22);
      t2 = s0 + ((a & b) ^ (a & c) ^ (b & c));
      hh = g; g = f; f = e; e = d + t1;
      d = c; c = b; b = a; a = t1 + t2;
    end
    return {h[255:224] + a, h[223:192] + b, h[191:160] + c, h[159:128] + d,
            h[127:96]  + e, h[95:64]    + f, h[63:32]    + g, h[31:0]     + hh};
  endfunction

  // ---------------- engine model + stability watch ----------------
  int           eng_cnt = 0;
  logic         eng_live = 1'b0;
  logic [511:0] eng_m = '0;
  logic [255:0] eng_h = '0;
  int           stab_bad = 0;

  always @(posedge clk) begin
    core_out_v <= 1'b0;
    if (core_in_v) begin
      eng_cnt <= 64;
    end else if (eng_cnt > 0) begin
      eng_cnt <= eng_cnt - 1;
      if (eng_cnt == 1) begin
        core_out_v <= 1'b1;
        core_H_out <= sha_compress(core_H_in, core_M);
      end
    end
    if (eng_live && rst_n && ((core_M !== eng_m) || (core_H_in !== eng_h)))
      stab_bad <= stab_bad + 1;
    if (core_out_v || !rst_n) eng_live <= 1'b0;
    if (core_in_v) begin
      eng_live <= 1'b1;
      eng_m    <= core_M;
      eng_h    <= core_H_in;
    end
  end

  // ---------------- output monitor ----------------
  int           n_load = 0;
  int           n_dig  = 0;
  int           rdy_bad = 0;
  logic [511:0] mblk [0:15];
  logic [255:0] hblk [0:15];
  logic [255:0] dig_cap = '0;

  always @(negedge clk) begin
    if (core_in_v) begin
      if (n_load < 16) begin
        mblk[n_load] = core_M;
        hblk[n_load] = core_H_in;
      end
      n_load++;
    end
    if (digest_v) begin
      n_dig++;
      dig_cap = digest;
    end
    if (eng_live && data_ready) rdy_bad++;
  end

  // ---------------- stimulus helpers ----------------
  logic [7:0] msg_q [$];

  task automatic send(input logic [7:0] b, input logic v, input logic e);
    int n = 0;
    while (!data_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (!data_ready) chk("send_ready_wait", 512'(data_ready), 512'(1));
    data_in = b;
    data_v  = v;
    msg_end = e;
    @(negedge clk);
    data_v  = 1'b0;
    msg_end = 1'b0;
  endtask

  // merge_end: raise msg_end together with the last byte
  task automatic send_msg(input logic merge_end);
    for (int i = 0; i < msg_q.size(); i++)
      send(msg_q[i], 1'b1, merge_end && (i == msg_q.size() - 1));
    if (!merge_end || msg_q.size() == 0) send(8'h00, 1'b0, 1'b1);
  endtask

  task automatic wait_digest(input int target);
    int n = 0;
    while (n_dig < target && n < 3000) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
    chk("digest_count", 512'(n_dig), 512'(target));
  endtask

  function automatic logic [511:0] blk_from_q(input int start, input int cnt);
    logic [511:0] r = '0;
    for (int i = 0; i < cnt; i++) r[511 - 8*i -: 8] = msg_q[start + i];
    return r;
  endfunction

  int           l0, d0, n;
  string        s56;
  logic [511:0] eb1, eb2;
  logic [255:0] eh;

  initial begin
    // ---------------- reset ----------------
    #2 rst_n = 1'b0;
    #1;
    chk("rst_ready",   512'(data_ready), 512'(0));
    chk("rst_in_v",    512'(core_in_v),  512'(0));
    chk("rst_dig_v",   512'(digest_v),   512'(0));
    chk("rst_digest",  512'(digest),     512'(0));
    chk("rst_h_in",    512'(core_H_in),  512'(IV));
    chk("rst_m",       core_M,           512'(0));
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1 chk("ready_pre_clk", 512'(data_ready), 512'(0));
    @(negedge clk);
    chk("ready_post_clk", 512'(data_ready), 512'(1));

    // ---------------- empty message ----------------
    l0 = n_load; d0 = n_dig;
    msg_q.delete();
    send_msg(1'b0);
    wait_digest(d0 + 1);
    chk("empty_loads",  512'(n_load - l0), 512'(1));
    chk("empty_blk",    mblk[l0], {8'h80, 504'd0});
    chk("empty_h_in",   512'(hblk[l0]), 512'(IV));
    chk("empty_digest", 512'(dig_cap), 512'(DIG_EMPTY));
    $display("[TB] msg empty: loads=%0d digest=%h", n_load - l0, dig_cap);

    // ---------------- "abc" ----------------
    l0 = n_load; d0 = n_dig;
    msg_q = '{8'h61, 8'h62, 8'h63};
    send_msg(1'b0);
    wait_digest(d0 + 1);
    chk("abc_loads",  512'(n_load - l0), 512'(1));
    chk("abc_blk",    mblk[l0], {32'h61626380, 416'd0, 64'h18});
    chk("abc_h_in",   512'(hblk[l0]), 512'(IV));
    chk("abc_digest", 512'(dig_cap), 512'(DIG_ABC));
    repeat (10) @(negedge clk);
    chk("abc_digest_hold", 512'(digest), 512'(DIG_ABC));
    $display("[TB] msg abc: loads=%0d digest=%h", n_load - l0, dig_cap);

    // ---------------- 56-byte message ----------------
    l0 = n_load; d0 = n_dig;
    s56 = "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq";
    msg_q.delete();
    for (int i = 0; i < s56.len(); i++) msg_q.push_back(s56[i]);
    eb1 = blk_from_q(0, 56);
    eb1[511 - 8*56 -: 8] = 8'h80;
    send_msg(1'b0);
    wait_digest(d0 + 1);
    chk("m56_loads",  512'(n_load - l0), 512'(2));
    chk("m56_blk0",   mblk[l0], eb1);
    chk("m56_blk1",   mblk[l0 + 1], {448'd0, 64'h1c0});
    chk("m56_digest", 512'(dig_cap), 512'(DIG_56));
    $display("[TB] msg 56B: loads=%0d digest=%h", n_load - l0, dig_cap);

    // ---------------- 64 bytes, msg_end with last byte ----------------
    l0 = n_load; d0 = n_dig;
    msg_q.delete();
    for (int i = 0; i < 64; i++) msg_q.push_back(8'(i * 7 + 3));
    eb1 = blk_from_q(0, 64);
    eb2 = {8'h80, 440'd0, 64'h200};
    eh  = sha_compress(sha_compress(IV, eb1), eb2);
    send_msg(1'b1);
    // bytes and ends offered during the hash must be dropped
    for (int i = 0; i < 20; i++) begin
      data_in = 8'hAA;
      data_v  = 1'b1;
      msg_end = (i % 3) == 0;
      @(negedge clk);
    end
    data_v = 1'b0;
    msg_end = 1'b0;
    wait_digest(d0 + 1);
    chk("m64_loads",  512'(n_load - l0), 512'(2));
    chk("m64_blk0",   mblk[l0], eb1);
    chk("m64_blk1",   mblk[l0 + 1], eb2);
    chk("m64_chain",  512'(hblk[l0 + 1]), 512'(sha_compress(IV, eb1)));
    chk("m64_digest", 512'(dig_cap), 512'(eh));
    chk("hash_ready_low", 512'(rdy_bad), 512'(0));
    $display("[TB] msg 64B: loads=%0d digest=%h", n_load - l0, dig_cap);

    // ---------------- reset in the middle of a hash ----------------
    l0 = n_load; d0 = n_dig;
    msg_q = '{8'h78, 8'h79, 8'h7a};
    send_msg(1'b0);
    n = 0;
    while (n_load == l0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("midrst_load", 512'(n_load), 512'(l0 + 1));
    repeat (20) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_in_v",  512'(core_in_v),  512'(0));
    chk("midrst_dig_v", 512'(digest_v),   512'(0));
    chk("midrst_ready", 512'(data_ready), 512'(0));
    chk("midrst_m",     core_M,           512'(0));
    chk("midrst_h_in",  512'(core_H_in),  512'(IV));
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    l0 = n_load;
    msg_q = '{8'h61, 8'h62, 8'h63};
    send_msg(1'b0);
    wait_digest(d0 + 1);
    chk("midrst_loads",  512'(n_load - l0), 512'(1));
    chk("midrst_blk",    mblk[l0], {32'h61626380, 416'd0, 64'h18});
    chk("midrst_digest", 512'(dig_cap), 512'(DIG_ABC));
    $display("[TB] msg abc after reset: loads=%0d digest=%h", n_load - l0, dig_cap);

    chk("hold_stable", 512'(stab_bad), 512'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sha256_block_feeder.md
Name: sha256_block_feeder

Overview:
- Upstream driver for the SHA-256 compression round engine.
- Accepts a message as a byte stream and applies SHA-256 padding (0x80, zero fill, 64-bit big-endian bit length).
- Presents each 512-bit block and the chaining value to the engine, pulses its load strobe, waits for its done strobe, and chains the result.
- Emits the final 256-bit digest with a one-cycle valid pulse.

Parameters:
- CNT_W, 32, width of the message byte counter. Length field = {zero-extend(byte_cnt), 3'b000}. Messages ≥ 2^CNT_W bytes are unsupported.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- data_in  input  8  message byte
- data_v  input  1  data_in valid; byte accepted when data_v && data_ready
- msg_end  input  1  end-of-message pulse; accepted when data_ready
- data_ready  output  1  feeder can accept a byte / msg_end this cycle
- core_H_in  output  256  chaining value to engine
- core_M  output  512  message block to engine
- core_in_v  output  1  one-cycle engine load strobe
- core_H_out  input  256  engine result (H_in + working vars)
- core_out_v  input  1  engine done strobe (64 cycles after load)
- digest  output  256  final hash, held until the next digest completes
- digest_v  output  1  one-cycle pulse, digest valid

Behaviour:
- Reset (async, rst_n=0), all of the following take effect immediately:
  - state=FILL, byte_cnt=0, blk_pos=0
  - H = IV 6a09e667 bb67ae85 3c6ef372 a54ff53a 510e527f 9b05688c 1f83d9ab 5be0cd19
  - core_in_v=0, digest_v=0, digest=0, data_ready=0 until first clock after release
  - Applies mid-hash too; any engine result then pending is ignored.
- Byte order: byte k of a block is placed at core_M[511-8k -: 8] (big-endian words, W0 = core_M[511:480]).
- FILL:
  - data_ready=1.
  - Accepted byte is written at blk_pos; blk_pos++, byte_cnt++.
  - When blk_pos wraps 63→0 (64th byte accepted) → HASH with ret=FILL.
  - msg_end accepted → PAD.
  - data_v and msg_end in the same cycle: the byte is taken first, then the end.
  - msg_end with no prior bytes hashes the empty message.
- PAD:
  - data_ready=0. One byte per cycle.
  - First cycle writes 0x80 at blk_pos. Following cycles write 0x00.
  - If blk_pos reaches 56 after 0x80 is written → LEN.
  - If 0x80 lands at positions 56..63, zero-fill to 63 → HASH (ret=PAD, 0x80 already done) → zero-fill positions 0..55 of the next block → LEN.
  - If 0x80 lands at position 63, the block is full → HASH; the next block is zeros 0..55.
- LEN (1 cycle): write the 64-bit length at bytes 56..63 → HASH with ret=DONE.
- HASH:
  - Cycle 0: core_in_v=1 for exactly one cycle.
  - core_M and core_H_in are held stable from the core_in_v cycle through the core_out_v cycle, because the engine adds H_in combinationally at its output.
  - On core_out_v: H <= core_H_out, clear the block buffer, blk_pos=0 → ret.
  - core_out_v seen outside HASH is ignored.
- DONE (1 cycle):
  - digest <= H, digest_v=1.
  - H <= IV, byte_cnt=0 → FILL.
- data_ready is 0 in PAD, LEN, HASH and DONE.
- Inputs presented while data_ready=0 are dropped; the source must hold them.
- Throughput: one block per 66 cycles min (1 load + 64 rounds + 1 capture), plus 64 fill cycles.
- Counter wrap: byte_cnt wraps modulo 2^CNT_W; behaviour beyond that is undefined.

Test Plan:
- Empty message: reset, msg_end only → exactly one core_in_v; digest = e3b0c442 98fc1c14 9afbf4c8 996fb924 27ae41e4 649b934c a495991b 7852b855, digest_v pulses once.
- "abc" (61 62 63) then msg_end → core_M = 61626380 00…00 00000018; digest = ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad.
- 56-byte "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq" → two core_in_v pulses; second block all zero except length 0x1c0; digest = 248d6a61 d20638b8 e5c02693 0c3e6039 a33ce459 64ff2167 f6ecedd4 19db06c1.
- Exactly 64 bytes, then msg_end in the same cycle as the 64th byte → first block hashed, then block 80 00…00 + length 0x200; data_ready=0 throughout both hashes; two core_in_v pulses.
- Stability check: during every HASH interval, core_M and core_H_in are unchanged from core_in_v through core_out_v; data_v pulses in HASH are not accepted (byte_cnt unchanged).
- Reset mid-hash: assert rst_n=0 20 cycles after core_in_v → immediately core_in_v=0, digest_v=0; after release, "abc" again yields the "abc" digest above, with no residue from the aborted message.
